ram_preload_seq: RTL and testbench
==================================

Name: ram_preload_seq

Overview:
- Boot-time sequencer that owns the single port of the 4x8 RAM.
- After reset it writes a fixed image into every RAM word, then reads each word back and compares it against the image.
- It then hands the port to the user side: address, write enable and data pass straight through.
- A user `start` pulse repeats the whole sequence. The block sits between board inputs (keys/switches) and the RAM4_8 instance.

Parameters:
- WORDSIZE, 8, data width in bits (the RAM address is also driven from a WORDSIZE-wide bus).
- DEPTH, 4, number of RAM words preloaded (indices 0..DEPTH-1).
- INIT_IMAGE, {8'd20,8'd32,8'd29,8'd74}, packed DEPTH*WORDSIZE image; word i = bits [i*WORDSIZE +: WORDSIZE], so word0 = 74.
- VERIFY, 1, 1 = run the readback phase; 0 = go straight to DONE after the writes.

Ports:
- init_clock, in, 1, block clock; the RAM is clocked by this same clock, with no clock muxing.
- init_reset, in, 1, asynchronous, active-high reset.
- start, in, 1, re-preload request; sampled only in DONE.
- user_addr, in, WORDSIZE, user address.
- user_data, in, WORDSIZE, user write data.
- user_we, in, 1, user write enable.
- ram_data_out, in, WORDSIZE, RAM read data.
- ram_addr, out, WORDSIZE, RAM address.
- ram_data_in, out, WORDSIZE, RAM write data.
- ram_write_en, out, 1, RAM write enable.
- user_rd_data, out, WORDSIZE, read data returned to the user.
- busy, out, 1, preload/verify in progress.
- done, out, 1, port handed to the user.
- error, out, 1, sticky verify-mismatch flag.
- err_addr, out, WORDSIZE, index of the first mismatching word.

Behaviour:
- Reset is asynchronous and active-high on init_reset; the clock is init_clock.
- States: BOOT, WRITE, VRD, VCMP, DONE. Index counter idx is clog2(DEPTH) bits wide (minimum 1 bit).
- Reset values: state=BOOT, idx=0, error=0, err_addr=0. Outputs during reset: ram_write_en=0, busy=1, done=0, ram_addr=0, ram_data_in=0, user_rd_data=0.
- All RAM-side outputs are decoded from state and idx (Moore outputs, no extra register stage).
- BOOT:
  - Outputs: we=0, busy=1.
  - Next edge: idx<=0, error<=0, err_addr<=0 → WRITE.
- WRITE:
  - Outputs: ram_addr=idx zero-extended, ram_data_in=INIT_IMAGE word idx, ram_write_en=1.
  - Each edge: idx<=idx+1.
  - At idx==DEPTH-1: idx<=0 and go to VRD if VERIFY=1, else DONE.
- VRD:
  - Outputs: ram_addr=idx, we=0.
  - Next edge → VCMP (one settle cycle; RAM read latency of 0 or 1 cycle is tolerated).
- VCMP:
  - Outputs: ram_addr=idx, we=0.
  - On the edge, if ram_data_out != image[idx] and error==0: error<=1, err_addr<=idx. Later mismatches do not overwrite err_addr.
  - If idx==DEPTH-1 → DONE; else idx<=idx+1 → VRD.
- DONE:
  - Outputs: ram_addr=user_addr, ram_data_in=user_data, ram_write_en=user_we, user_rd_data=ram_data_out, busy=0, done=1.
  - start=1 on an edge → BOOT. A user_we in that same cycle still takes effect.
- Outside DONE:
  - user_we, user_addr and user_data are ignored; ram_write_en is never driven by the user.
  - user_rd_data=0; start is ignored.
- Latency with VERIFY=1: done rises 1+DEPTH+2*DEPTH edges after reset release (13 for DEPTH=4).
- Latency with VERIFY=0: done rises 1+DEPTH edges after reset release (5 for DEPTH=4).
- error holds its value through DONE and clears only in BOOT.
- Reset mid-operation: returns to BOOT immediately. ram_write_en drops asynchronously and the preload restarts from word 0.
- DEPTH greater than 2^WORDSIZE is illegal; flag it with an elaboration-time check.

Decomposition:
- Shared package/defines: WORDSIZE, the state encodings (BOOT=0, WRITE=1, VRD=2, VCMP=3, DONE=4, 3-bit), and the default image constants 74/29/32/20.
- One natural sub-module, ram_preload_rom:
  - Combinational index → word decode of INIT_IMAGE, parameterised by WORDSIZE and DEPTH.
  - Used for both the write data and the compare data.

Test Plan:
- Reset release, VERIFY=1, behavioural RAM → 4 write cycles to addresses 0..3 with data 74,29,32,20; done=1 exactly 13 edges after release; error=0.
- In DONE, user_addr=2, user_we=0 → user_rd_data=32. Then user_we=1, user_data=99, addr=2 for one cycle; read of addr 2 → 99.
- RAM model with word 1 stuck at 0 → error=1, err_addr=1 at done. Word 3 also corrupted → err_addr stays 1.
- Assert start in DONE after the user wrote 99 to addr 2 → busy=1 next cycle; re-preload restores addr 2 to 32; error cleared.
- Pulse init_reset during WRITE at idx=2 → ram_write_en=0 immediately (asynchronous); sequence restarts at addr 0; done after 13 edges.
- user_we=1 held during preload → no RAM write from user_data; all ram_write_en pulses carry image data only. start during busy is ignored.

Source files
------------

// File: rtl/ram_preload_seq_pkg.sv
// Shared constants and state encoding for the RAM preload sequencer.
// The default image is the boot contents of the 4x8 RAM, word 0 first.
package ram_preload_seq_pkg;

    localparam int unsigned WORDSIZE      = 8;
    localparam int unsigned DEFAULT_DEPTH = 4;

    localparam logic [WORDSIZE-1:0] IMG_WORD0 = 8'd74;
    localparam logic [WORDSIZE-1:0] IMG_WORD1 = 8'd29;
    localparam logic [WORDSIZE-1:0] IMG_WORD2 = 8'd32;
    localparam logic [WORDSIZE-1:0] IMG_WORD3 = 8'd20;

    localparam logic [DEFAULT_DEPTH*WORDSIZE-1:0] DEFAULT_IMAGE =
        {IMG_WORD3, IMG_WORD2, IMG_WORD1, IMG_WORD0};

    typedef enum logic [2:0] {
        StBoot  = 3'd0,
        StWrite = 3'd1,
        StVrd   = 3'd2,
        StVcmp  = 3'd3,
        StDone  = 3'd4
    } state_e;

    // Index counter width; a single-word RAM still needs one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ram_preload_rom.sv
// Combinational index-to-word decode of the packed preload image.
// Shared by the write path and the readback compare.
module ram_preload_rom #(
    parameter int unsigned                 WORDSIZE = 8,
    parameter int unsigned                 DEPTH    = 4,
    parameter logic [DEPTH*WORDSIZE-1:0]   IMAGE    = '0
) (
    input  logic [ram_preload_seq_pkg::idx_width(DEPTH)-1:0] idx_i,
    output logic [WORDSIZE-1:0]                               word_o
);

    localparam int unsigned IdxW = ram_preload_seq_pkg::idx_width(DEPTH);

    always_comb begin
        word_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (idx_i == IdxW'(i)) begin
                word_o = IMAGE[i*WORDSIZE +: WORDSIZE];
            end
        end
    end

endmodule

// File: rtl/ram_preload_seq.sv
// Boot sequencer owning the RAM port: preload image, optional readback verify,
// then transparent hand-over to the user side until the next start pulse.
module ram_preload_seq #(
    parameter int unsigned               WORDSIZE   = ram_preload_seq_pkg::WORDSIZE,
    parameter int unsigned               DEPTH      = ram_preload_seq_pkg::DEFAULT_DEPTH,
    parameter logic [DEPTH*WORDSIZE-1:0] INIT_IMAGE = ram_preload_seq_pkg::DEFAULT_IMAGE,
    parameter bit                        VERIFY     = 1'b1
) (
    input  logic                init_clock,
    input  logic                init_reset,
    input  logic                start,
    input  logic [WORDSIZE-1:0] user_addr,
    input  logic [WORDSIZE-1:0] user_data,
    input  logic                user_we,
    input  logic [WORDSIZE-1:0] ram_data_out,
    output logic [WORDSIZE-1:0] ram_addr,
    output logic [WORDSIZE-1:0] ram_data_in,
    output logic                ram_write_en,
    output logic [WORDSIZE-1:0] user_rd_data,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [WORDSIZE-1:0] err_addr
);

    import ram_preload_seq_pkg::*;

    localparam int unsigned     IdxW    = idx_width(DEPTH);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

    if ((DEPTH == 0) || ($clog2(DEPTH) > WORDSIZE)) begin : g_depth_check
        $error("ram_preload_seq: DEPTH must be 1..2**WORDSIZE");
    end

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic                error_q, error_d;
    logic [WORDSIZE-1:0] err_addr_q, err_addr_d;
    logic [WORDSIZE-1:0] img_word;

    ram_preload_rom #(
        .WORDSIZE (WORDSIZE),
        .DEPTH    (DEPTH),
        .IMAGE    (INIT_IMAGE)
    ) u_rom (
        .idx_i  (idx_q),
        .word_o (img_word)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        error_d    = error_q;
        err_addr_d = err_addr_q;
        unique case (state_q)
            StBoot: begin
                idx_d      = '0;
                error_d    = 1'b0;
                err_addr_d = '0;
                state_d    = StWrite;
            end
            StWrite: begin
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = VERIFY ? StVrd : StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StVrd: state_d = StVcmp;
            StVcmp: begin
                // Only the first mismatch is recorded.
                if ((ram_data_out != img_word) && !error_q) begin
                    error_d    = 1'b1;
                    err_addr_d = WORDSIZE'(idx_q);
                end
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StVrd;
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StBoot;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge init_clock or posedge init_reset) begin
        if (init_reset) begin
            state_q    <= StBoot;
            idx_q      <= '0;
            error_q    <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            error_q    <= error_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Moore decode so reset forces the write enable low without waiting for a clock.
    always_comb begin
        ram_addr     = '0;
        ram_data_in  = '0;
        ram_write_en = 1'b0;
        user_rd_data = '0;
        busy         = 1'b1;
        done         = 1'b0;
        unique case (state_q)
            StWrite: begin
                ram_addr     = WORDSIZE'(idx_q);
                ram_data_in  = img_word;
                ram_write_en = 1'b1;
            end
            StVrd, StVcmp: ram_addr = WORDSIZE'(idx_q);
            StDone: begin
                ram_addr     = user_addr;
                ram_data_in  = user_data;
                ram_write_en = user_we;
                user_rd_data = ram_data_out;
                busy         = 1'b0;
                done         = 1'b1;
            end
            default: ;
        endcase
    end

    assign error    = error_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_ram_preload_seq.sv
// Scoreboard bench for ram_preload_seq with a behavioural 4x8 RAM and
// optional read-fault injection on words 1 and 3.
module tb_ram_preload_seq;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic       err;
        logic [7:0] addr;
    } done_t;

    logic       init_clock = 1'b0;
    logic       init_reset = 1'b1;
    logic       start      = 1'b0;
    logic [7:0] user_addr  = '0;
    logic [7:0] user_data  = '0;
    logic       user_we    = 1'b0;
    logic [7:0] ram_data_out;
    logic [7:0] ram_addr;
    logic [7:0] ram_data_in;
    logic       ram_write_en;
    logic [7:0] user_rd_data;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] err_addr;

    logic [7:0] mem [4];
    logic       fault1   = 1'b0;
    logic       fault3   = 1'b0;
    logic       rd_strobe = 1'b0;
    logic       done_prev = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    wr_t        wr_q[$];
    done_t      done_q[$];
    logic [7:0] rd_q[$];

    logic [7:0] img [4] = '{8'd74, 8'd29, 8'd32, 8'd20};

    ram_preload_seq dut (
        .init_clock   (init_clock),
        .init_reset   (init_reset),
        .start        (start),
        .user_addr    (user_addr),
        .user_data    (user_data),
        .user_we      (user_we),
        .ram_data_out (ram_data_out),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_write_en (ram_write_en),
        .user_rd_data (user_rd_data),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_addr     (err_addr)
    );

    always #5 init_clock = ~init_clock;

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 8'hA5;
    end

    always @(posedge init_clock) begin
        if (ram_write_en) mem[ram_addr[1:0]] <= ram_data_in;
    end

    always_comb begin
        ram_data_out = mem[ram_addr[1:0]];
        if (fault1 && ram_addr[1:0] == 2'd1) ram_data_out = 8'd0;
        if (fault3 && ram_addr[1:0] == 2'd3) ram_data_out = ~mem[3];
    end

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: pops the matching queue whenever the DUT presents an event.
    always @(negedge init_clock) begin
        if (!init_reset) begin
            if (ram_write_en) begin
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    check("write_addr", ram_addr, w.addr);
                    check("write_data", ram_data_in, w.data);
                end
            end
            if (done && !done_prev) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("done_error", error, d.err);
                    check("done_err_addr", err_addr, d.addr);
                end
            end
            if (rd_strobe) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", 1, 0);
                end else begin
                    check("user_rd_data", user_rd_data, rd_q.pop_front());
                end
            end
        end
        done_prev <= done;
    end

    task automatic push_preload(input logic exp_err, input logic [7:0] exp_addr);
        for (int i = 0; i < 4; i++) wr_q.push_back('{addr: 8'(i), data: img[i]});
        done_q.push_back('{err: exp_err, addr: exp_addr});
    endtask

    task automatic wait_done(input int exp_edges, input int drop_at);
        int n = 0;
        while (!done && n < 60) begin
            @(posedge init_clock);
            #1;
            n++;
            if (n == drop_at) begin
                start   = 1'b0;
                user_we = 1'b0;
            end
        end
        check("done_latency", n, exp_edges);
    endtask

    task automatic run_start(input logic exp_err, input logic [7:0] exp_addr);
        push_preload(exp_err, exp_addr);
        @(posedge init_clock);
        #1 start = 1'b1;
        @(posedge init_clock);
        #1 start = 1'b0;
        check("busy_after_start", busy, 1);
        check("done_after_start", done, 0);
        wait_done(13, 0);
    endtask

    task automatic user_read(input logic [7:0] addr, input logic [7:0] exp);
        @(posedge init_clock);
        #1;
        user_addr = addr;
        user_we   = 1'b0;
        rd_strobe = 1'b1;
        rd_q.push_back(exp);
        @(posedge init_clock);
        #1 rd_strobe = 1'b0;
    endtask

    task automatic user_write(input logic [7:0] addr, input logic [7:0] data);
        @(posedge init_clock);
        #1;
        user_addr = addr;
        user_data = data;
        user_we   = 1'b1;
        wr_q.push_back('{addr: addr, data: data});
        @(posedge init_clock);
        #1 user_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with user write and start held active: both must be ignored.
        user_we   = 1'b1;
        user_data = 8'hEE;
        user_addr = 8'd3;
        start     = 1'b1;
        repeat (2) @(posedge init_clock);
        @(negedge init_clock);
        check("rst_write_en", ram_write_en, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data_in", ram_data_in, 0);
        check("rst_rd_data", user_rd_data, 0);
        check("rst_error", error, 0);
        check("rst_err_addr", err_addr, 0);

        push_preload(1'b0, 8'd0);
        init_reset = 1'b0;
        wait_done(13, 10);

        // User hand-over: read, write 99, read back.
        user_read(8'd2, 8'd32);
        user_read(8'd0, 8'd74);
        user_write(8'd2, 8'd99);
        user_read(8'd2, 8'd99);

        // Word 3 corrupted alone, then words 1 and 3: first mismatch wins.
        fault3 = 1'b1;
        run_start(1'b1, 8'd3);
        fault1 = 1'b1;
        run_start(1'b1, 8'd1);
        repeat (3) @(posedge init_clock);
        #1;
        check("error_held", error, 1);
        check("err_addr_held", err_addr, 1);
        fault1 = 1'b0;
        fault3 = 1'b0;

        // Re-preload restores word 2 and clears the sticky error.
        user_write(8'd2, 8'd99);
        run_start(1'b0, 8'd0);
        user_read(8'd2, 8'd32);

        // Asynchronous reset while writing word 2.
        wr_q.push_back('{addr: 8'd0, data: img[0]});
        wr_q.push_back('{addr: 8'd1, data: img[1]});
        @(posedge init_clock);
        #1 start = 1'b1;
        @(posedge init_clock);
        #1 start = 1'b0;
        repeat (3) @(posedge init_clock);
        #1;
        check("pre_rst_addr", ram_addr, 2);
        check("pre_rst_we", ram_write_en, 1);
        #1 init_reset = 1'b1;
        #1;
        check("async_rst_we", ram_write_en, 0);
        check("async_rst_addr", ram_addr, 0);
        check("async_rst_busy", busy, 1);
        @(posedge init_clock);
        @(negedge init_clock);
        push_preload(1'b0, 8'd0);
        init_reset = 1'b0;
        wait_done(13, 0);
        user_read(8'd3, 8'd20);

        repeat (2) @(posedge init_clock);
        check("wr_q_drained", wr_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
